// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream offer/accept and downstream present/accept.
// master = environment driving the stage, slave = the stage itself.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with flush-to-bubble, cleared ctrl field and saturating stall counter.
// Define RV_PIPE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int CTRL_W      = 16,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   clr_stats,
  pipe_stage_reg_if.slave        bus,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // Encoding equals the number of held entries so occupancy is the state register.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              out_valid;
  logic              in_ready;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = out_valid & bus.out_ready;

`ifdef RV_PIPE_SKID_EN
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              in_ready_q;

  assign in_ready = in_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      data_q      <= '0;
      ctrl_q      <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // Data is kept for debug; only validity and ctrl are dropped.
      state_q    <= EMPTY;
      ctrl_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_q <= ONE;
          data_q  <= bus.in_data;
          ctrl_q  <= bus.in_ctrl;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            data_q <= bus.in_data;
            ctrl_q <= bus.in_ctrl;
          end else if (in_fire) begin
            state_q     <= TWO;
            skid_data_q <= bus.in_data;
            skid_ctrl_q <= bus.in_ctrl;
            in_ready_q  <= 1'b0;
          end else if (out_fire) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
          end
        end
        TWO: if (out_fire) begin
          state_q    <= ONE;
          data_q     <= skid_data_q;
          ctrl_q     <= skid_ctrl_q;
          in_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= EMPTY;
          ctrl_q     <= '0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end
`else
  // Pass-through accept: a full stage takes a new entry in the cycle it hands one off.
  assign in_ready = ~out_valid | bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      ctrl_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_q <= ONE;
          data_q  <= bus.in_data;
          ctrl_q  <= bus.in_ctrl;
        end
        ONE: begin
          if (in_fire) begin
            data_q <= bus.in_data;
            ctrl_q <= bus.in_ctrl;
          end else if (out_fire) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
          end
        end
        default: begin
          state_q <= EMPTY;
          ctrl_q  <= '0;
        end
      endcase
    end
  end
`endif

  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clr_stats)
      stall_d = '0;
    else if (out_valid && !bus.out_ready && !(&stall_q))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data_q;
  assign bus.out_ctrl  = ctrl_q;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed phases then random traffic against a queue model.
// A narrow stall counter is used so saturation is reached quickly.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam int SW = 3;
  localparam int STALL_MAX = (1 << SW) - 1;
`ifdef RV_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          clr_stats;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bif ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .clr_stats (clr_stats),
    .bus       (bif),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          exp_q[$];
  logic [DW-1:0] last_data = '0;
  int            stall_m = 0;
  bit            m_in_ready = 1'b1;
  bit            popped = 1'b0;
  bit            accepted = 1'b0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares presented state against the model, then retires delivered entries.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      last_data  = '0;
      stall_m    = 0;
      m_in_ready = 1'b1;
      popped     = 1'b0;
    end else begin
      bit has;
      has = (exp_q.size() != 0);
      if (CAP == 2) m_in_ready = (exp_q.size() < 2);
      else          m_in_ready = !has || bif.out_ready;
      check("out_valid", 32'(bif.out_valid), 32'(has));
      check("occupancy", 32'(occupancy), 32'(exp_q.size()));
      check("in_ready", 32'(bif.in_ready), 32'(m_in_ready));
      check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
      if (has) begin
        check("out_data", bif.out_data, exp_q[0].d);
        check("out_ctrl", 32'(bif.out_ctrl), 32'(exp_q[0].c));
      end else begin
        check("out_data_hold", bif.out_data, last_data);
        check("out_ctrl_zero", 32'(bif.out_ctrl), 32'(0));
      end
      if (has && bif.out_ready) begin
        last_data = exp_q[0].d;
        void'(exp_q.pop_front());
        popped = 1'b1;
      end
      if (clr_stats)                              stall_m = 0;
      else if (has && !bif.out_ready && stall_m < STALL_MAX) stall_m++;
    end
  end

  // Stimulus side of the scoreboard: record accepted entries, apply flush.
  always @(posedge clk) begin
    accepted = 1'b0;
    if (!reset) begin
      if (flush) begin
        if (exp_q.size() != 0 && !popped) last_data = exp_q[0].d;
        exp_q.delete();
      end else if (bif.in_valid && m_in_ready) begin
        exp_q.push_back('{d: bif.in_data, c: bif.in_ctrl});
        accepted = 1'b1;
      end
    end
    popped = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b0;
    flush         = 1'b0;
    clr_stats     = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bif.in_data = base + DW'(i);
      bif.in_ctrl = CW'(16'h00a0 + i);
      step();
    end
    bif.in_valid = 1'b0;
  endtask

  initial begin
    int k;
    int guard;
    reset = 1'b1;
    bif.in_data = '0;
    bif.in_ctrl = '0;
    idle_inputs();
    repeat (2) step();
    check("rst_out_valid", 32'(bif.out_valid), 32'(0));
    check("rst_in_ready", 32'(bif.in_ready), 32'(1));
    reset = 1'b0;
    step();

    // In-order stream with downstream always ready.
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bif.in_data = DW'(32'h100 + i);
      bif.in_ctrl = CW'(i + 1);
      step();
    end
    bif.in_valid = 1'b0;
    repeat (2) step();

    // Three offers against a stalled consumer, then release.
    k = 0;
    guard = 0;
    bif.out_ready = 1'b0;
    while (k < 3 && guard < 40) begin
      bif.in_valid  = 1'b1;
      bif.in_data   = DW'(32'h200 + k);
      bif.in_ctrl   = CW'(16'h0010 + k);
      bif.out_ready = (guard >= 6);
      step();
      if (accepted) k++;
      guard++;
    end
    check("three_accepted", 32'(k), 32'(3));
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    repeat (4) step();

    // Flush a full stage with an input offered in the same cycle.
    fill(32'h300);
    bif.in_valid = 1'b1;
    bif.in_data  = 32'hdead_beef;
    bif.in_ctrl  = 16'hffff;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bif.in_valid = 1'b0;
    repeat (2) step();

    // Stall counting to saturation, then clear while still stalled.
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    bif.in_valid = 1'b1;
    bif.in_data  = 32'h400;
    bif.in_ctrl  = 16'h0400;
    bif.out_ready = 1'b0;
    step();
    bif.in_valid = 1'b0;
    repeat (10) step();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    repeat (2) step();
    bif.out_ready = 1'b1;
    repeat (3) step();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bif.in_valid  = ($urandom_range(0, 3) != 0);
      bif.in_data   = $urandom;
      bif.in_ctrl   = CW'($urandom);
      bif.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      clr_stats     = ($urandom_range(0, 63) == 0);
      step();
    end
    idle_inputs();
    step();

    // Asynchronous reset in the middle of a cycle with the stage full.
    fill(32'h500);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bif.out_valid), 32'(0));
    check("arst_in_ready", 32'(bif.in_ready), 32'(1));
    check("arst_occupancy", 32'(occupancy), 32'(0));
    check("arst_out_data", bif.out_data, 32'(0));
    check("arst_out_ctrl", 32'(bif.out_ctrl), 32'(0));
    check("arst_stall_cnt", 32'(stall_cnt), 32'(0));
    step();
    reset = 1'b0;
    bif.out_ready = 1'b1;
    bif.in_valid  = 1'b1;
    bif.in_data   = 32'h600;
    bif.in_ctrl   = 16'h0600;
    step();
    bif.in_valid = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
